// File: rtl/pe_mw_pkg.sv
// Shared widths, result type and arithmetic helpers for the multi-weight systolic PE.
// The helper functions are sized to the package operand/psum widths.
package pe_mw_pkg;

    localparam int IN_W   = 8;
    localparam int ACC_W  = 32;
    localparam int OPND_W = IN_W + 1;
    localparam int PROD_W = 2 * IN_W + 2;
    localparam int SUM_W  = ACC_W + 1;

    typedef struct packed {
        logic [ACC_W-1:0] value;
        logic             overflow;
    } sat_res_t;

    function automatic logic signed [OPND_W-1:0] ext_operand(
        input logic [IN_W-1:0] x,
        input logic            signed_mode
    );
        return {signed_mode & x[IN_W-1], x};
    endfunction

    // The sum is formed one bit wider than the psum, so a range overflow shows up
    // as a disagreement between the top two bits.
    function automatic sat_res_t sat_add(
        input logic signed [ACC_W-1:0]  a,
        input logic signed [PROD_W-1:0] b,
        input logic                     sat_en
    );
        logic signed [SUM_W-1:0] sum;
        sat_res_t                r;
        sum        = SUM_W'(a) + SUM_W'(b);
        r.value    = sum[ACC_W-1:0];
        r.overflow = 1'b0;
        if (sat_en && (sum[SUM_W-1] != sum[SUM_W-2])) begin
            r.overflow = 1'b1;
            r.value    = sum[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_weight_bank.sv
// Slot-addressed weight bank with one write port and a registered active weight.
// A switch in the same cycle as a write to that slot picks up the old contents.
module pe_weight_bank #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int SLOT_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [SLOT_W-1:0] wr_slot,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              sw_en,
    input  logic [SLOT_W-1:0] sw_slot,
    output logic [DATA_W-1:0] active
);

    logic [DATA_W-1:0] bank [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the bank is small and must read as zero after reset, so every slot is reset explicitly.
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
            active <= '0;
        end else begin
            // NOTE: non-blocking assignment gives read-before-write when wr_slot == sw_slot.
            if (wr_en) begin
                bank[wr_slot] <= wr_data;
            end
            if (sw_en) begin
                active <= bank[sw_slot];
            end
        end
    end

endmodule

// File: rtl/pe_mw.sv
// Weight-stationary systolic PE: signed/unsigned MAC against a multi-slot weight bank,
// optional saturating accumulation and a sticky overflow flag.
module pe_mw
    import pe_mw_pkg::*;
#(
    parameter int ROW_ID           = 0,
    parameter int ARRAY_WIDTH      = 16,
    parameter int DATA_WIDTH_IN    = IN_W,
    parameter int DATA_WIDTH_ACCUM = ACC_W,
    parameter int WEIGHT_DEPTH     = 4,
    parameter int SATURATE         = 1,
    localparam int IDX_W           = $clog2(ARRAY_WIDTH),
    localparam int SLOT_W          = $clog2(WEIGHT_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pe_enabled,
    input  logic                        pe_valid_in,
    input  logic                        pe_signed_in,
    input  logic                        pe_switch_in,
    input  logic [SLOT_W-1:0]           pe_switch_slot_in,
    input  logic                        pe_accept_w_in,
    input  logic [DATA_WIDTH_IN-1:0]    pe_weight_in,
    input  logic [IDX_W-1:0]            pe_index_in,
    input  logic [SLOT_W-1:0]           pe_wslot_in,
    input  logic [DATA_WIDTH_ACCUM-1:0] pe_psum_in,
    input  logic                        pe_psum_valid_in,
    input  logic [DATA_WIDTH_IN-1:0]    pe_input_in,
    input  logic                        pe_sat_clr_in,
    output logic [DATA_WIDTH_IN-1:0]    pe_weight_out,
    output logic [IDX_W-1:0]            pe_index_out,
    output logic [SLOT_W-1:0]           pe_wslot_out,
    output logic                        pe_accept_w_out,
    output logic [DATA_WIDTH_ACCUM-1:0] pe_psum_out,
    output logic                        pe_psum_valid_out,
    output logic [DATA_WIDTH_IN-1:0]    pe_input_out,
    output logic                        pe_valid_out,
    output logic                        pe_signed_out,
    output logic                        pe_switch_out,
    output logic [SLOT_W-1:0]           pe_switch_slot_out,
    output logic                        pe_sat_flag
);

    logic                       w_match;
    logic [DATA_WIDTH_IN-1:0]   active_w;
    logic signed [OPND_W-1:0]   a_ext;
    logic signed [OPND_W-1:0]   b_ext;
    logic signed [PROD_W-1:0]   product;
    sat_res_t                   mac;

    assign w_match = pe_accept_w_in && (pe_index_in == IDX_W'(ROW_ID));

    pe_weight_bank #(
        .DATA_W (DATA_WIDTH_IN),
        .DEPTH  (WEIGHT_DEPTH),
        .SLOT_W (SLOT_W)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (pe_enabled && w_match),
        .wr_slot (pe_wslot_in),
        .wr_data (pe_weight_in),
        .sw_en   (pe_enabled && pe_switch_in),
        .sw_slot (pe_switch_slot_in),
        .active  (active_w)
    );

    // NOTE: every variable is assigned on every pass, so no latch can be inferred.
    always_comb begin
        a_ext   = ext_operand(active_w, pe_signed_in);
        b_ext   = ext_operand(pe_input_in, pe_signed_in);
        product = PROD_W'(a_ext) * PROD_W'(b_ext);
        mac     = sat_add($signed(pe_psum_in), product, SATURATE != 0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_weight_out      <= '0;
            pe_index_out       <= '0;
            pe_wslot_out       <= '0;
            pe_accept_w_out    <= 1'b0;
            pe_psum_out        <= '0;
            pe_psum_valid_out  <= 1'b0;
            pe_input_out       <= '0;
            pe_valid_out       <= 1'b0;
            pe_signed_out      <= 1'b0;
            pe_switch_out      <= 1'b0;
            pe_switch_slot_out <= '0;
            pe_sat_flag        <= 1'b0;
        end else begin
            if (pe_enabled) begin
                pe_input_out       <= pe_input_in;
                pe_valid_out       <= pe_valid_in;
                pe_signed_out      <= pe_signed_in;
                pe_switch_out      <= pe_switch_in;
                pe_switch_slot_out <= pe_switch_slot_in;
                // A matching weight is consumed here; anything else accepted travels south.
                if (pe_accept_w_in && !w_match) begin
                    pe_weight_out   <= pe_weight_in;
                    pe_index_out    <= pe_index_in;
                    pe_wslot_out    <= pe_wslot_in;
                    pe_accept_w_out <= 1'b1;
                end else begin
                    pe_weight_out   <= '0;
                    pe_index_out    <= '0;
                    pe_wslot_out    <= '0;
                    pe_accept_w_out <= 1'b0;
                end
                if (pe_valid_in) begin
                    pe_psum_out       <= mac.value;
                    pe_psum_valid_out <= 1'b1;
                end else begin
                    pe_psum_out       <= pe_psum_in;
                    pe_psum_valid_out <= 1'b0;
                end
                if (pe_valid_in && mac.overflow) begin
                    pe_sat_flag <= 1'b1;
                end else if (pe_sat_clr_in) begin
                    pe_sat_flag <= 1'b0;
                end
            end else begin
                pe_input_out       <= '0;
                pe_valid_out       <= 1'b0;
                pe_signed_out      <= 1'b0;
                pe_switch_out      <= 1'b0;
                pe_switch_slot_out <= '0;
                pe_weight_out      <= '0;
                pe_index_out       <= '0;
                pe_wslot_out       <= '0;
                pe_accept_w_out    <= 1'b0;
                pe_psum_out        <= pe_psum_in;
                pe_psum_valid_out  <= pe_psum_valid_in;
            end
        end
    end

endmodule

// File: tb/tb_pe_mw.sv
// Directed bench for pe_mw: a vector table for the single-cycle behaviour plus
// hand-written sequences for same-slot switch, saturation and async reset.
module tb_pe_mw;

    localparam int ROW = 2;

    logic        clk;
    logic        rst_n;
    logic        pe_enabled, pe_valid_in, pe_signed_in, pe_switch_in;
    logic [1:0]  pe_switch_slot_in;
    logic        pe_accept_w_in;
    logic [7:0]  pe_weight_in;
    logic [3:0]  pe_index_in;
    logic [1:0]  pe_wslot_in;
    logic [31:0] pe_psum_in;
    logic        pe_psum_valid_in;
    logic [7:0]  pe_input_in;
    logic        pe_sat_clr_in;

    logic [7:0]  s_weight_out, w_weight_out;
    logic [3:0]  s_index_out, w_index_out;
    logic [1:0]  s_wslot_out, w_wslot_out;
    logic        s_accept_w_out, w_accept_w_out;
    logic [31:0] s_psum_out, w_psum_out;
    logic        s_psum_valid_out, w_psum_valid_out;
    logic [7:0]  s_input_out, w_input_out;
    logic        s_valid_out, w_valid_out;
    logic        s_signed_out, w_signed_out;
    logic        s_switch_out, w_switch_out;
    logic [1:0]  s_switch_slot_out, w_switch_slot_out;
    logic        s_sat_flag, w_sat_flag;

    int n_checks = 0;
    int n_errors = 0;

    pe_mw #(.ROW_ID(ROW), .ARRAY_WIDTH(16), .DATA_WIDTH_IN(8), .DATA_WIDTH_ACCUM(32),
            .WEIGHT_DEPTH(4), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .pe_enabled(pe_enabled), .pe_valid_in(pe_valid_in),
        .pe_signed_in(pe_signed_in), .pe_switch_in(pe_switch_in),
        .pe_switch_slot_in(pe_switch_slot_in), .pe_accept_w_in(pe_accept_w_in),
        .pe_weight_in(pe_weight_in), .pe_index_in(pe_index_in), .pe_wslot_in(pe_wslot_in),
        .pe_psum_in(pe_psum_in), .pe_psum_valid_in(pe_psum_valid_in),
        .pe_input_in(pe_input_in), .pe_sat_clr_in(pe_sat_clr_in),
        .pe_weight_out(s_weight_out), .pe_index_out(s_index_out), .pe_wslot_out(s_wslot_out),
        .pe_accept_w_out(s_accept_w_out), .pe_psum_out(s_psum_out),
        .pe_psum_valid_out(s_psum_valid_out), .pe_input_out(s_input_out),
        .pe_valid_out(s_valid_out), .pe_signed_out(s_signed_out),
        .pe_switch_out(s_switch_out), .pe_switch_slot_out(s_switch_slot_out),
        .pe_sat_flag(s_sat_flag)
    );

    pe_mw #(.ROW_ID(ROW), .ARRAY_WIDTH(16), .DATA_WIDTH_IN(8), .DATA_WIDTH_ACCUM(32),
            .WEIGHT_DEPTH(4), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .pe_enabled(pe_enabled), .pe_valid_in(pe_valid_in),
        .pe_signed_in(pe_signed_in), .pe_switch_in(pe_switch_in),
        .pe_switch_slot_in(pe_switch_slot_in), .pe_accept_w_in(pe_accept_w_in),
        .pe_weight_in(pe_weight_in), .pe_index_in(pe_index_in), .pe_wslot_in(pe_wslot_in),
        .pe_psum_in(pe_psum_in), .pe_psum_valid_in(pe_psum_valid_in),
        .pe_input_in(pe_input_in), .pe_sat_clr_in(pe_sat_clr_in),
        .pe_weight_out(w_weight_out), .pe_index_out(w_index_out), .pe_wslot_out(w_wslot_out),
        .pe_accept_w_out(w_accept_w_out), .pe_psum_out(w_psum_out),
        .pe_psum_valid_out(w_psum_valid_out), .pe_input_out(w_input_out),
        .pe_valid_out(w_valid_out), .pe_signed_out(w_signed_out),
        .pe_switch_out(w_switch_out), .pe_switch_slot_out(w_switch_slot_out),
        .pe_sat_flag(w_sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int unsigned en, valid, sgn, sw, sw_slot, acc, w, idx, wslot;
        int unsigned psum, pv, b, clr;
        int unsigned e_psum, e_pv, e_acc, e_w, e_idx, e_wslot;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t idle_vec();
        vec_t v;
        v = '{"idle", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        return v;
    endfunction

    task automatic apply(input vec_t v);
        pe_enabled        = 1'(v.en);
        pe_valid_in       = 1'(v.valid);
        pe_signed_in      = 1'(v.sgn);
        pe_switch_in      = 1'(v.sw);
        pe_switch_slot_in = 2'(v.sw_slot);
        pe_accept_w_in    = 1'(v.acc);
        pe_weight_in      = 8'(v.w);
        pe_index_in       = 4'(v.idx);
        pe_wslot_in       = 2'(v.wslot);
        pe_psum_in        = v.psum;
        pe_psum_valid_in  = 1'(v.pv);
        pe_input_in       = 8'(v.b);
        pe_sat_clr_in     = 1'(v.clr);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[13];
    vec_t v;

    initial begin
        //           name             en vl sg sw ss ac w     idx ws psum        pv b     clr  e_psum     e_pv e_acc e_w   e_idx e_ws
        vecs[0]  = '{"load_s1",       1, 0, 1, 0, 0, 1, 'hFD, 2,  1, 0,          0, 0,    0,   0,         0,   0,    0,    0,    0};
        vecs[1]  = '{"switch_s1",     1, 0, 1, 1, 1, 0, 0,    0,  0, 0,          0, 0,    0,   0,         0,   0,    0,    0,    0};
        vecs[2]  = '{"mac_signed",    1, 1, 1, 0, 0, 0, 0,    0,  0, 100,        0, 5,    0,   85,        1,   0,    0,    0,    0};
        vecs[3]  = '{"load_s2",       1, 0, 1, 0, 0, 1, 'hFF, 2,  2, 7,          0, 0,    0,   7,         0,   0,    0,    0,    0};
        vecs[4]  = '{"switch_s2",     1, 0, 1, 1, 2, 0, 0,    0,  0, 0,          0, 0,    0,   0,         0,   0,    0,    0,    0};
        vecs[5]  = '{"mac_unsigned",  1, 1, 0, 0, 0, 0, 0,    0,  0, 0,          0, 'hFF, 0,   65025,     1,   0,    0,    0,    0};
        vecs[6]  = '{"mac_signed_ff", 1, 1, 1, 0, 0, 0, 0,    0,  0, 0,          0, 'hFF, 0,   1,         1,   0,    0,    0,    0};
        vecs[7]  = '{"fwd_nomatch",   1, 0, 1, 0, 0, 1, 'h5A, 5,  3, 0,          0, 0,    0,   0,         0,   1,    'h5A, 5,    3};
        vecs[8]  = '{"no_accept",     1, 0, 1, 0, 0, 0, 'h33, 2,  2, 0,          0, 0,    0,   0,         0,   0,    0,    0,    0};
        vecs[9]  = '{"disabled_pass", 0, 1, 1, 1, 1, 1, 'h11, 2,  2, 42,         1, 9,    0,   42,        1,   0,    0,    0,    0};
        vecs[10] = '{"reenable_mac",  1, 1, 1, 0, 0, 0, 0,    0,  0, 10,         0, 3,    0,   7,         1,   0,    0,    0,    0};
        vecs[11] = '{"switch_s2_rep", 1, 0, 1, 1, 2, 0, 0,    0,  0, 0,          0, 0,    0,   0,         0,   0,    0,    0,    0};
        vecs[12] = '{"mac_s2_kept",   1, 1, 1, 0, 0, 0, 0,    0,  0, 10,         0, 3,    0,   7,         1,   0,    0,    0,    0};

        rst_n = 1'b0;
        apply(idle_vec());
        #2;
        check("reset_psum", s_psum_out, 32'd0);
        check("reset_psum_valid", 32'(s_psum_valid_out), 32'd0);
        check("reset_accept_w", 32'(s_accept_w_out), 32'd0);
        check("reset_sat_flag", 32'(s_sat_flag), 32'd0);
        #6 rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            apply(vecs[i]);
            tick();
            check({vecs[i].name, "_psum"},    s_psum_out, vecs[i].e_psum);
            check({vecs[i].name, "_psum_wrap"}, w_psum_out, vecs[i].e_psum);
            check({vecs[i].name, "_pvalid"},  32'(s_psum_valid_out), vecs[i].e_pv);
            check({vecs[i].name, "_accept"},  32'(s_accept_w_out), vecs[i].e_acc);
            check({vecs[i].name, "_w_out"},   32'(s_weight_out), vecs[i].e_w);
            check({vecs[i].name, "_idx_out"}, 32'(s_index_out), vecs[i].e_idx);
            check({vecs[i].name, "_ws_out"},  32'(s_wslot_out), vecs[i].e_wslot);
            check({vecs[i].name, "_in_out"},  32'(s_input_out), vecs[i].en != 0 ? vecs[i].b : 0);
            check({vecs[i].name, "_vld_out"}, 32'(s_valid_out), vecs[i].en != 0 ? vecs[i].valid : 0);
            check({vecs[i].name, "_sw_out"},  32'(s_switch_out), vecs[i].en != 0 ? vecs[i].sw : 0);
            check({vecs[i].name, "_sat"},     32'(s_sat_flag), 32'd0);
        end

        // Same-slot load and switch: active takes the old slot value.
        v = idle_vec(); v.acc = 1; v.w = 4; v.idx = ROW; v.wslot = 0;
        apply(v); tick();
        v = idle_vec(); v.sw = 1; v.sw_slot = 0;
        apply(v); tick();
        v = idle_vec(); v.acc = 1; v.w = 9; v.idx = ROW; v.wslot = 0; v.sw = 1; v.sw_slot = 0;
        apply(v); tick();
        check("same_slot_accept", 32'(s_accept_w_out), 32'd0);
        v = idle_vec(); v.valid = 1; v.b = 1;
        apply(v); tick();
        check("same_slot_old", s_psum_out, 32'd4);
        v = idle_vec(); v.sw = 1; v.sw_slot = 0;
        apply(v); tick();
        v = idle_vec(); v.valid = 1; v.b = 1;
        apply(v); tick();
        check("same_slot_new", s_psum_out, 32'd9);

        // Positive and negative saturation against the wrapping instance.
        v = idle_vec(); v.acc = 1; v.w = 'h7F; v.idx = ROW; v.wslot = 3;
        apply(v); tick();
        v = idle_vec(); v.sw = 1; v.sw_slot = 3;
        apply(v); tick();
        v = idle_vec(); v.valid = 1; v.b = 'h7F; v.psum = 'h7FFF_FFF0;
        apply(v); tick();
        check("sat_pos_value", s_psum_out, 32'h7FFF_FFFF);
        check("sat_pos_flag", 32'(s_sat_flag), 32'd1);
        check("wrap_pos_value", w_psum_out, 32'h8000_3EF1);
        check("wrap_pos_flag", 32'(w_sat_flag), 32'd0);
        apply(idle_vec()); tick();
        check("sat_flag_holds", 32'(s_sat_flag), 32'd1);
        v = idle_vec(); v.clr = 1;
        apply(v); tick();
        check("sat_flag_cleared", 32'(s_sat_flag), 32'd0);
        v = idle_vec(); v.valid = 1; v.b = 'h81; v.psum = 'h8000_0000; v.clr = 1;
        apply(v); tick();
        check("sat_neg_value", s_psum_out, 32'h8000_0000);
        check("sat_set_over_clr", 32'(s_sat_flag), 32'd1);
        check("wrap_neg_value", w_psum_out, 32'h7FFF_C0FF);

        // Asynchronous reset in the middle of a saturating MAC.
        v = idle_vec(); v.valid = 1; v.b = 'h7F; v.psum = 'h7FFF_FFF0;
        apply(v); tick();
        check("pre_reset_psum", s_psum_out, 32'h7FFF_FFFF);
        #3 rst_n = 1'b0;
        #1;
        check("async_psum", s_psum_out, 32'd0);
        check("async_pvalid", 32'(s_psum_valid_out), 32'd0);
        check("async_vld_out", 32'(s_valid_out), 32'd0);
        check("async_in_out", 32'(s_input_out), 32'd0);
        check("async_sat_flag", 32'(s_sat_flag), 32'd0);
        #1 rst_n = 1'b1;
        apply(idle_vec());
        v = idle_vec(); v.sw = 1; v.sw_slot = 3;
        apply(v); tick();
        v = idle_vec(); v.valid = 1; v.b = 1; v.psum = 5;
        apply(v); tick();
        check("bank_cleared", s_psum_out, 32'd5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
